// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store
// funct3 codes, the responder state encoding and the delay-LFSR seed.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one memory access (purely combinational).
// In: wen, funct3, addr_lo, wdata, rword. Out: be, wword, rdata, err.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        wen,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        err
);

  logic [4:0]  bsh;
  logic [31:0] sh;

  assign bsh   = {addr_lo, 3'b000};
  assign sh    = rword >> bsh;
  assign wword = wdata << bsh;

  always_comb begin
    be    = 4'b0000;
    rdata = 32'h0;
    err   = 1'b0;
    unique case (funct3)
      F3_B: begin
        be    = 4'b0001 << addr_lo;
        rdata = {{24{sh[7]}}, sh[7:0]};
      end
      F3_BU: begin
        // unsigned sizes exist for loads only
        err   = wen;
        rdata = {24'h0, sh[7:0]};
      end
      F3_H: begin
        err   = addr_lo[0];
        be    = 4'b0011 << addr_lo;
        rdata = {{16{sh[15]}}, sh[15:0]};
      end
      F3_HU: begin
        err   = wen | addr_lo[0];
        rdata = {16'h0, sh[15:0]};
      end
      F3_W: begin
        err   = |addr_lo;
        be    = 4'b1111;
        rdata = rword;
      end
      default: err = 1'b1;
    endcase
    if (err) begin
      be    = 4'b0000;
      rdata = 32'h0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, fixed latency.
// Ports: clk/rst, req_* (valid/ready request), rsp_* (valid/ready reply).
// Optional DMEM_RANDOM_DELAY_EN adds 0..3 LFSR-driven extra cycles.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [4:0] LAT_M1 = 5'(LATENCY - 1);

  state_e              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d, cnt_init;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                wen_q, wen_d;
  logic [2:0]          f3_q, f3_d;
  logic [1:0]          alo_q, alo_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                enter_resp;
  logic                mem_we;

  logic [31:0]         mem_q [2**ADDR_W];
  logic [31:0]         rword;
  logic [3:0]          al_be;
  logic [31:0]         al_wword, al_rdata;
  logic                al_err;

  // upper address bits alias onto the array
  logic [31-ADDR_W-2:0] unused_addr_hi;
  assign unused_addr_hi = req_addr[31:ADDR_W+2];

`ifdef DMEM_RANDOM_DELAY_EN
  logic [7:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[6:0],
                   lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign cnt_init = LAT_M1 + {3'b000, lfsr_q[1:0]};
`else
  assign cnt_init = LAT_M1;
`endif

  // Lane logic sees the request as it will be held after this edge, so
  // a zero-wait access (IDLE straight to RESP) uses the live inputs.
  assign rword = mem_q[idx_d];

  dmem_lane_align u_align (
    .wen     (wen_d),
    .funct3  (f3_d),
    .addr_lo (alo_d),
    .wdata   (wdata_d),
    .rword   (rword),
    .be      (al_be),
    .wword   (al_wword),
    .rdata   (al_rdata),
    .err     (al_err)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wen_d       = wen_q;
    f3_d        = f3_q;
    alo_d       = alo_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    enter_resp  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wen_d       = req_wen;
          f3_d        = req_funct3;
          alo_d       = req_addr[1:0];
          idx_d       = req_addr[ADDR_W+1:2];
          wdata_d     = req_wdata;
          cnt_d       = cnt_init;
          req_ready_d = 1'b0;
          if (cnt_init == 5'd0) enter_resp = 1'b1;
          else                  state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 5'd1) enter_resp = 1'b1;
        else               cnt_d      = cnt_q - 5'd1;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (enter_resp) begin
      state_d     = ST_RESP;
      cnt_d       = 5'd0;
      rsp_valid_d = 1'b1;
      rsp_rdata_d = wen_d ? 32'h0 : al_rdata;
      rsp_err_d   = al_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 5'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      wen_q       <= 1'b0;
      f3_q        <= 3'b000;
      alo_q       <= 2'b00;
      idx_q       <= '0;
      wdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wen_q       <= wen_d;
      f3_q        <= f3_d;
      alo_q       <= alo_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
    end
  end

  // a reset on the edge that would enter RESP cancels the store
  assign mem_we = enter_resp & wen_d & ~rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (al_be[i]) mem_q[idx_d][8*i +: 8] <= al_wword[8*i +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
